exu_wb: RTL and testbench
=========================

# exu_wb

Parameterised write-back stage for the execute unit. It accepts one retiring instruction at a time over a valid/ready handshake and selects the destination value from the ALU result, the immediate, or a memory load response. For loads it waits for a multi-cycle memory response and sign- or zero-extends byte, half, word or double data. It then issues a single registered general-purpose-register write pulse and a retire strobe. It sits between the execute datapath/LSU and the GPR file, and supports RV32 or RV64.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- REG_ADDR_W, 5, GPR index width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  retiring instruction present.
- in_ready  out  1  stage can accept an instruction.
- in_src_sel  in  2  value source: 0 = none (store/branch/ebreak), 1 = ALU, 2 = immediate, 3 = memory load.
- in_rd  in  REG_ADDR_W  destination register index.
- in_alu_result  in  XLEN  ALU output.
- in_imm  in  XLEN  decoded immediate (lui).
- in_ld_size  in  2  load size: 0 = byte, 1 = half, 2 = word, 3 = double.
- in_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- in_addr_lo  in  3  low bits of the load address.
- mem_r_valid  in  1  load data valid (single-cycle pulse).
- mem_r_data  in  XLEN  naturally aligned load data word.
- gpr_w_en  out  1  GPR write strobe.
- gpr_w_addr  out  REG_ADDR_W  GPR write index.
- gpr_w_data  out  XLEN  GPR write data.
- wb_done  out  1  retire pulse, one per accepted instruction.

## Operation
- FSM states: IDLE, WAIT_MEM, COMMIT.
- in_ready = 1 only in IDLE. An accept occurs when in_valid && in_ready.
- Accept captures in_src_sel, in_rd, the load attributes, and the selected non-load value (ALU or immediate).
- Transitions out of IDLE on accept:
  - src_sel = 3 → WAIT_MEM.
  - any other src_sel → COMMIT.
- WAIT_MEM: on mem_r_valid, the formatted load data is captured → COMMIT. Otherwise the FSM stays in WAIT_MEM indefinitely; there is no timeout.
- mem_r_valid outside WAIT_MEM is ignored.
- COMMIT lasts exactly one cycle, then → IDLE.
  - wb_done = 1.
  - gpr_w_en = (src_sel != 0) && (rd != 0).
  - gpr_w_addr = captured rd. gpr_w_data = captured value.
- Load formatting:
  - Byte offset = in_addr_lo mod (XLEN/8), with the low bits masked to the size alignment: half clears bit0, word clears bits[1:0], double clears all.
  - Data is shifted right by 8 × offset, then the low 8/16/32/64 bits are extended to XLEN per in_ld_unsigned.
  - With XLEN = 32, size 3 is treated as word, and word-unsigned is identical to word-signed.
- src_sel = 0 still passes through COMMIT, so wb_done pulses while gpr_w_en stays 0.
- Output hold rules:
  - gpr_w_en and wb_done are 0 in all states except COMMIT.
  - gpr_w_addr and gpr_w_data hold their last committed values outside COMMIT.

## Timing
- All outputs are registered; no combinational path from any input to any output except in_ready, which is decoded from state only.
- Reset values: state = IDLE, in_ready = 1, gpr_w_en = 0, wb_done = 0, gpr_w_addr = 0, gpr_w_data = 0.
- Non-load: accept at cycle N → COMMIT (write visible) at cycle N+1 → in_ready = 1 at cycle N+2. Throughput is one instruction per 2 cycles.
- Load: accept at cycle N → WAIT_MEM from N+1. mem_r_valid at cycle M ≥ N+1 → COMMIT at M+1 → IDLE at M+2.
- in_valid asserted while in_ready = 0 is not accepted. Upstream must hold its fields stable until the accept.
- Reset asserted mid-operation (WAIT_MEM or COMMIT):
  - The FSM returns to IDLE immediately and all outputs go to their reset values asynchronously.
  - The pending write is dropped.
  - A mem_r_valid arriving after reset deassertion is ignored.

## Test plan
- Reset: hold rst = 0 for 3 cycles with random inputs → in_ready = 1, gpr_w_en = 0, wb_done = 0, gpr_w_addr = 0, gpr_w_data = 0 throughout.
- ALU write: src_sel = 1, rd = 5, in_alu_result = 0x12345678 accepted at cycle N → cycle N+1: gpr_w_en = 1, addr = 5, data = 0x12345678, wb_done = 1; cycle N+2: in_ready = 1, gpr_w_en = 0.
- Byte loads (XLEN = 32): size 0, addr_lo = 2, mem_r_data = 0x00800000, mem_r_valid 3 cycles after accept:
  - signed → data 0xFFFFFF80 one cycle after mem_r_valid.
  - unsigned → data 0x00000080.
- Half and word loads:
  - XLEN = 32, size 1, addr_lo = 3 (aligned to 2), data 0x80010000, signed → 0xFFFF8001.
  - XLEN = 64, size 2, unsigned, addr_lo = 4, data 0x80000000_00000000 → 0x00000000_80000000.
- No-write cases: rd = 0 with src_sel = 1, and src_sel = 0 with rd = 7 → wb_done = 1, gpr_w_en = 0, and gpr_w_data unchanged from the previous commit.
- Reset in WAIT_MEM: accept a load, assert rst for 1 cycle, then pulse mem_r_valid → no gpr_w_en, no wb_done, in_ready = 1; the next ALU instruction commits normally.

Source files
------------

// File: rtl/exu_wb.sv
// exu_wb -- execute-unit write-back stage.
//
// Takes one retiring instruction at a time over in_valid/in_ready and
// produces a single registered GPR write pulse plus a retire strobe.
// The destination value is the ALU result, the immediate, or a load
// response that is aligned and sign/zero-extended here.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake (ready only when idle)
//   in_src_sel          0 none, 1 ALU, 2 immediate, 3 memory load
//   in_rd               destination register index
//   in_alu_result       ALU output
//   in_imm              decoded immediate
//   in_ld_size          0 byte, 1 half, 2 word, 3 double
//   in_ld_unsigned      1 zero-extend, 0 sign-extend
//   in_addr_lo          low bits of the load address
//   mem_r_valid/data    load response (single-cycle pulse)
//   gpr_w_en/addr/data  registered GPR write port
//   wb_done             registered retire pulse
module exu_wb #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_src_sel,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [2:0]            in_addr_lo,
  input  logic                  mem_r_valid,
  input  logic [XLEN-1:0]       mem_r_data,
  output logic                  gpr_w_en,
  output logic [REG_ADDR_W-1:0] gpr_w_addr,
  output logic [XLEN-1:0]       gpr_w_data,
  output logic                  wb_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [1:0]              ld_size_q, ld_size_d;
  logic                    ld_uns_q, ld_uns_d;
  logic [2:0]              addr_lo_q, addr_lo_d;
  logic                    gpr_w_en_q, gpr_w_en_d;
  logic [REG_ADDR_W-1:0]   gpr_w_addr_q, gpr_w_addr_d;
  logic [XLEN-1:0]         gpr_w_data_q, gpr_w_data_d;
  logic                    wb_done_q, wb_done_d;
  logic [XLEN-1:0]         ld_fmt_s;

  // Align and extend a naturally aligned load word. Sign/zero extension
  // is done with a keep-mask so the same code serves both XLEN values;
  // for a full-width access the mask is all ones and extension vanishes.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] data,
    input logic [1:0]      size,
    input logic            uns,
    input logic [2:0]      addr_lo
  );
    logic [1:0]      sz;
    logic [2:0]      off;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sbit;
    if (XLEN == 32 && size == 2'd3) begin
      sz = 2'd2;
    end else begin
      sz = size;
    end
    off = addr_lo;
    if (XLEN == 32) begin
      off[2] = 1'b0;
    end else begin
      off[2] = addr_lo[2];
    end
    case (sz)
      2'd0:    off = off;
      2'd1:    off[0] = 1'b0;
      2'd2:    off[1:0] = 2'b00;
      default: off = 3'd0;
    endcase
    sh = data >> {off, 3'b000};
    case (sz)
      2'd0: begin
        keep = XLEN'(8'hFF);
        sbit = sh[7];
      end
      2'd1: begin
        keep = XLEN'(16'hFFFF);
        sbit = sh[15];
      end
      2'd2: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sbit = sh[31];
      end
      default: begin
        keep = '1;
        sbit = sh[XLEN-1];
      end
    endcase
    return (sh & keep) | ((!uns && sbit) ? ~keep : '0);
  endfunction

  assign ld_fmt_s = fmt_load(mem_r_data, ld_size_q, ld_uns_q, addr_lo_q);

  // Next-state and next-output decode; outputs are pre-computed on the
  // transition into COMMIT so that they are registered during COMMIT.
  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    ld_size_d    = ld_size_q;
    ld_uns_d     = ld_uns_q;
    addr_lo_d    = addr_lo_q;
    gpr_w_en_d   = 1'b0;
    wb_done_d    = 1'b0;
    gpr_w_addr_d = gpr_w_addr_q;
    gpr_w_data_d = gpr_w_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_d      = in_rd;
          ld_size_d = in_ld_size;
          ld_uns_d  = in_ld_unsigned;
          addr_lo_d = in_addr_lo;
          if (in_src_sel == 2'd3) begin
            state_d = WAIT_MEM;
          end else begin
            state_d      = COMMIT;
            wb_done_d    = 1'b1;
            gpr_w_addr_d = in_rd;
            gpr_w_en_d   = (in_src_sel != 2'd0) && (in_rd != '0);
            // Data only moves on a real write so no-write retires keep
            // the last committed value on the bus.
            if (gpr_w_en_d) begin
              gpr_w_data_d = (in_src_sel == 2'd2) ? in_imm : in_alu_result;
            end else begin
              gpr_w_data_d = gpr_w_data_q;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_r_valid) begin
          state_d      = COMMIT;
          wb_done_d    = 1'b1;
          gpr_w_addr_d = rd_q;
          gpr_w_en_d   = (rd_q != '0);
          if (rd_q != '0) begin
            gpr_w_data_d = ld_fmt_s;
          end else begin
            gpr_w_data_d = gpr_w_data_q;
          end
        end else begin
          state_d = WAIT_MEM;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured attributes and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      ld_size_q    <= 2'd0;
      ld_uns_q     <= 1'b0;
      addr_lo_q    <= 3'd0;
      gpr_w_en_q   <= 1'b0;
      gpr_w_addr_q <= '0;
      gpr_w_data_q <= '0;
      wb_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      ld_size_q    <= ld_size_d;
      ld_uns_q     <= ld_uns_d;
      addr_lo_q    <= addr_lo_d;
      gpr_w_en_q   <= gpr_w_en_d;
      gpr_w_addr_q <= gpr_w_addr_d;
      gpr_w_data_q <= gpr_w_data_d;
      wb_done_q    <= wb_done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign gpr_w_en   = gpr_w_en_q;
  assign gpr_w_addr = gpr_w_addr_q;
  assign gpr_w_data = gpr_w_data_q;
  assign wb_done    = wb_done_q;

endmodule

// File: tb/tb_exu_wb.sv
// Table-driven bench for exu_wb with an RV32 and an RV64 instance.
module tb_exu_wb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RV32 instance signals
  logic        a_valid, a_ready, a_uns, a_mvalid, a_wen, a_done;
  logic [1:0]  a_src, a_size;
  logic [4:0]  a_rd, a_waddr;
  logic [2:0]  a_addr;
  logic [31:0] a_alu, a_imm, a_mdata, a_wdata;

  // RV64 instance signals
  logic        b_valid, b_ready, b_uns, b_mvalid, b_wen, b_done;
  logic [1:0]  b_src, b_size;
  logic [4:0]  b_rd, b_waddr;
  logic [2:0]  b_addr;
  logic [63:0] b_alu, b_imm, b_mdata, b_wdata;

  exu_wb #(.XLEN(32), .REG_ADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_src_sel(a_src), .in_rd(a_rd), .in_alu_result(a_alu), .in_imm(a_imm),
    .in_ld_size(a_size), .in_ld_unsigned(a_uns), .in_addr_lo(a_addr),
    .mem_r_valid(a_mvalid), .mem_r_data(a_mdata), .gpr_w_en(a_wen),
    .gpr_w_addr(a_waddr), .gpr_w_data(a_wdata), .wb_done(a_done)
  );

  exu_wb #(.XLEN(64), .REG_ADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_src_sel(b_src), .in_rd(b_rd), .in_alu_result(b_alu), .in_imm(b_imm),
    .in_ld_size(b_size), .in_ld_unsigned(b_uns), .in_addr_lo(b_addr),
    .mem_r_valid(b_mvalid), .mem_r_data(b_mdata), .gpr_w_en(b_wen),
    .gpr_w_addr(b_waddr), .gpr_w_data(b_wdata), .wb_done(b_done)
  );

  typedef struct {
    bit          w64;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] imm;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  addr;
    logic [63:0] mdata;
    int          delay;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[14];
  vec_t v;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic set_idle();
    a_valid = 1'b0; a_src = 2'd0; a_rd = 5'd0; a_alu = 32'd0; a_imm = 32'd0;
    a_size = 2'd0; a_uns = 1'b0; a_addr = 3'd0; a_mvalid = 1'b0; a_mdata = 32'd0;
    b_valid = 1'b0; b_src = 2'd0; b_rd = 5'd0; b_alu = 64'd0; b_imm = 64'd0;
    b_size = 2'd0; b_uns = 1'b0; b_addr = 3'd0; b_mvalid = 1'b0; b_mdata = 64'd0;
  endtask

  task automatic get_out(input bit w64, output logic rdy, output logic en,
                         output logic done, output logic [4:0] ad,
                         output logic [63:0] d);
    if (w64) begin
      rdy = b_ready; en = b_wen; done = b_done; ad = b_waddr; d = b_wdata;
    end else begin
      rdy = a_ready; en = a_wen; done = a_done; ad = a_waddr; d = 64'(a_wdata);
    end
  endtask

  task automatic set_mvalid(input bit w64, input logic val);
    if (w64) b_mvalid = val;
    else     a_mvalid = val;
  endtask

  // Runs one instruction starting just after a negedge, ends after a negedge.
  task automatic do_op(input vec_t t, input string nm);
    logic rdy, en, done;
    logic [4:0] ad;
    logic [63:0] d;
    get_out(t.w64, rdy, en, done, ad, d);
    chk({nm, " ready_before"}, 64'(rdy), 64'd1);
    if (t.w64) begin
      b_src = t.src; b_rd = t.rd; b_alu = t.alu; b_imm = t.imm; b_size = t.size;
      b_uns = t.uns; b_addr = t.addr; b_mdata = t.mdata; b_valid = 1'b1;
    end else begin
      a_src = t.src; a_rd = t.rd; a_alu = t.alu[31:0]; a_imm = t.imm[31:0];
      a_size = t.size; a_uns = t.uns; a_addr = t.addr; a_mdata = t.mdata[31:0];
      a_valid = 1'b1;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (t.src == 2'd3) begin
      get_out(t.w64, rdy, en, done, ad, d);
      chk({nm, " ready_waitmem"}, 64'(rdy), 64'd0);
      chk({nm, " done_waitmem"}, 64'(done), 64'd0);
      repeat (t.delay - 1) @(negedge clk);
      set_mvalid(t.w64, 1'b1);
      @(negedge clk);
      set_mvalid(t.w64, 1'b0);
    end
    get_out(t.w64, rdy, en, done, ad, d);
    chk({nm, " en"}, 64'(en), 64'(t.exp_en));
    chk({nm, " addr"}, 64'(ad), 64'(t.exp_addr));
    chk({nm, " data"}, d, t.exp_data);
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " ready_commit"}, 64'(rdy), 64'd0);
    @(negedge clk);
    get_out(t.w64, rdy, en, done, ad, d);
    chk({nm, " en_after"}, 64'(en), 64'd0);
    chk({nm, " done_after"}, 64'(done), 64'd0);
    chk({nm, " ready_after"}, 64'(rdy), 64'd1);
    chk({nm, " data_hold"}, d, t.exp_data);
  endtask

  initial begin
    //        w64  src  rd     alu                    imm                    size uns addr mdata                  dly en  addr   data
    tbl[0]  = '{1'b0, 2'd1, 5'd5,  64'h12345678,       64'h0,                 2'd0, 1'b0, 3'd0, 64'h0,                0, 1'b1, 5'd5,  64'h12345678};
    tbl[1]  = '{1'b0, 2'd2, 5'd3,  64'h11111111,       64'hABCD0000,          2'd0, 1'b0, 3'd0, 64'h0,                0, 1'b1, 5'd3,  64'hABCD0000};
    tbl[2]  = '{1'b0, 2'd3, 5'd9,  64'h0,              64'h0,                 2'd0, 1'b0, 3'd2, 64'h00800000,         3, 1'b1, 5'd9,  64'hFFFFFF80};
    tbl[3]  = '{1'b0, 2'd3, 5'd10, 64'h0,              64'h0,                 2'd0, 1'b1, 3'd2, 64'h00800000,         3, 1'b1, 5'd10, 64'h00000080};
    tbl[4]  = '{1'b0, 2'd3, 5'd11, 64'h0,              64'h0,                 2'd1, 1'b0, 3'd3, 64'h80010000,         2, 1'b1, 5'd11, 64'hFFFF8001};
    tbl[5]  = '{1'b0, 2'd3, 5'd12, 64'h0,              64'h0,                 2'd3, 1'b1, 3'd5, 64'h80000001,         1, 1'b1, 5'd12, 64'h80000001};
    tbl[6]  = '{1'b0, 2'd1, 5'd0,  64'hDEADBEEF,       64'h0,                 2'd0, 1'b0, 3'd0, 64'h0,                0, 1'b0, 5'd0,  64'h80000001};
    tbl[7]  = '{1'b0, 2'd0, 5'd7,  64'h00005555,       64'h0,                 2'd0, 1'b0, 3'd0, 64'h0,                0, 1'b0, 5'd7,  64'h80000001};
    tbl[8]  = '{1'b0, 2'd3, 5'd31, 64'h0,              64'h0,                 2'd1, 1'b1, 3'd1, 64'h1234F00D,         2, 1'b1, 5'd31, 64'h0000F00D};
    tbl[9]  = '{1'b0, 2'd3, 5'd1,  64'h0,              64'h0,                 2'd0, 1'b0, 3'd7, 64'h7F000000,         1, 1'b1, 5'd1,  64'h0000007F};
    tbl[10] = '{1'b1, 2'd3, 5'd4,  64'h0,              64'h0,                 2'd2, 1'b1, 3'd4, 64'h8000000000000000, 3, 1'b1, 5'd4,  64'h0000000080000000};
    tbl[11] = '{1'b1, 2'd3, 5'd5,  64'h0,              64'h0,                 2'd2, 1'b0, 3'd4, 64'h8000000000000000, 2, 1'b1, 5'd5,  64'hFFFFFFFF80000000};
    tbl[12] = '{1'b1, 2'd3, 5'd6,  64'h0,              64'h0,                 2'd3, 1'b0, 3'd6, 64'h8123456789ABCDEF, 1, 1'b1, 5'd6,  64'h8123456789ABCDEF};
    tbl[13] = '{1'b1, 2'd3, 5'd8,  64'h0,              64'h0,                 2'd0, 1'b0, 3'd7, 64'h80FF00FF00FF00FF, 2, 1'b1, 5'd8,  64'hFFFFFFFFFFFFFF80};

    // Reset held for three cycles with random inputs.
    set_idle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_valid = 1'($urandom); a_src = 2'($urandom); a_rd = 5'($urandom);
      a_alu = $urandom; a_mvalid = 1'($urandom); a_mdata = $urandom;
      b_valid = 1'($urandom); b_src = 2'($urandom); b_mvalid = 1'($urandom);
      b_alu = {$urandom, $urandom};
      @(negedge clk);
      chk("rst ready", 64'(a_ready), 64'd1);
      chk("rst en", 64'(a_wen), 64'd0);
      chk("rst done", 64'(a_done), 64'd0);
      chk("rst addr", 64'(a_waddr), 64'd0);
      chk("rst data", 64'(a_wdata), 64'd0);
      chk("rst64 data", b_wdata, 64'd0);
    end
    set_idle();
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i], $sformatf("v%0d", i));
    end

    // in_valid held through COMMIT must not be accepted a second time.
    a_src = 2'd1; a_rd = 5'd2; a_alu = 32'h00000042; a_valid = 1'b1;
    @(negedge clk);
    a_rd = 5'd3; a_alu = 32'h00000099;
    chk("hold en", 64'(a_wen), 64'd1);
    chk("hold data", 64'(a_wdata), 64'h42);
    @(negedge clk);
    a_valid = 1'b0;
    chk("hold no_accept en", 64'(a_wen), 64'd0);
    chk("hold no_accept ready", 64'(a_ready), 64'd1);
    chk("hold no_accept done", 64'(a_done), 64'd0);

    // Stray load response while idle is ignored.
    a_mvalid = 1'b1; a_mdata = 32'hFFFF0000;
    @(negedge clk);
    a_mvalid = 1'b0;
    chk("idle_mem done", 64'(a_done), 64'd0);
    chk("idle_mem en", 64'(a_wen), 64'd0);
    chk("idle_mem data", 64'(a_wdata), 64'h42);

    // Reset while waiting for memory drops the pending write.
    a_src = 2'd3; a_rd = 5'd13; a_size = 2'd2; a_uns = 1'b0; a_addr = 3'd0;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    chk("rstwm ready_wait", 64'(a_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstwm async ready", 64'(a_ready), 64'd1);
    chk("rstwm async addr", 64'(a_waddr), 64'd0);
    chk("rstwm async data", 64'(a_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    a_mvalid = 1'b1; a_mdata = 32'h00001234;
    @(negedge clk);
    a_mvalid = 1'b0;
    chk("rstwm en", 64'(a_wen), 64'd0);
    chk("rstwm done", 64'(a_done), 64'd0);
    chk("rstwm ready", 64'(a_ready), 64'd1);
    @(negedge clk);
    chk("rstwm en2", 64'(a_wen), 64'd0);
    chk("rstwm done2", 64'(a_done), 64'd0);
    set_idle();
    v = '{1'b0, 2'd1, 5'd5, 64'hCAFEF00D, 64'h0, 2'd0, 1'b0, 3'd0, 64'h0, 0, 1'b1, 5'd5, 64'hCAFEF00D};
    do_op(v, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
